// File: rtl/alu_req_pkg.sv
// Shared types and constants for the ALU start/done requester.
package alu_req_pkg;

    localparam int unsigned DEFAULT_W   = 8;
    localparam int unsigned DEFAULT_OPW = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StRel  = 2'd2,
        StRsp  = 2'd3
    } req_state_e;

    // Controller state codes as reported on alu_state.
    localparam logic [1:0] ALU_ST_IDLE = 2'b00;
    localparam logic [1:0] ALU_ST_CALC = 2'b01;
    localparam logic [1:0] ALU_ST_FIN  = 2'b10;

endpackage

// File: rtl/alu_req_timer.sv
// REQ-phase watchdog: cleared on load, counts while enabled, flags the last allowed cycle.
module alu_req_timer #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic reset_a,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] count_q;

    // expired is high during the TIMEOUT_CYC-th enabled cycle after load.
    assign expired = (count_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_requester.sv
// Initiator side of the ALU start/done handshake with a valid/ready command and response port.
// Optional REQ-phase timeout abort is enabled by defining ALU_REQ_TIMEOUT_EN.
module alu_requester
    import alu_req_pkg::*;
#(
    parameter int unsigned W           = DEFAULT_W,
    parameter int unsigned OPW         = DEFAULT_OPW,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic           clk,
    input  logic           reset_a,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [OPW-1:0] cmd_op,
    input  logic [W-1:0]   cmd_a,
    input  logic [W-1:0]   cmd_b,
    output logic           alu_start,
    output logic [OPW-1:0] alu_op,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    input  logic           alu_done,
    input  logic [1:0]     alu_state,
    input  logic [W-1:0]   alu_result,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [W-1:0]   rsp_result,
    output logic           rsp_error,
    output logic           busy,
    output logic [7:0]     txn_count
);

    if (TIMEOUT_CYC < 1) begin : g_param_check
        $error("TIMEOUT_CYC must be at least 1");
    end

    req_state_e     state_q, state_d;
    logic           start_q, start_d;
    logic [OPW-1:0] op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [W-1:0]   result_q, result_d;
    logic [7:0]     txn_q, txn_d;

`ifdef ALU_REQ_TIMEOUT_EN
    logic error_q, error_d;
    logic timer_load, timer_en, timer_expired;

    alu_req_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .reset_a(reset_a),
        .load   (timer_load),
        .enable (timer_en),
        .expired(timer_expired)
    );

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign rsp_error = error_q;
`else
    assign rsp_error = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid_q;
        result_d    = result_q;
        txn_d       = txn_q;
`ifdef ALU_REQ_TIMEOUT_EN
        error_d     = error_q;
        timer_load  = 1'b0;
        timer_en    = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    start_d = 1'b1;
                    state_d = StReq;
`ifdef ALU_REQ_TIMEOUT_EN
                    timer_load = 1'b1;
`endif
                end
            end
            StReq: begin
`ifdef ALU_REQ_TIMEOUT_EN
                timer_en = 1'b1;
`endif
                // A done arriving on the expiry cycle still counts as normal completion.
                if (alu_done) begin
                    result_d = alu_result;
                    start_d  = 1'b0;
                    state_d  = StRel;
`ifdef ALU_REQ_TIMEOUT_EN
                    error_d  = 1'b0;
                end else if (timer_expired) begin
                    result_d = '0;
                    error_d  = 1'b1;
                    start_d  = 1'b0;
                    state_d  = StRel;
`endif
                end
            end
            StRel: begin
                if (alu_state == ALU_ST_IDLE) begin
                    rsp_valid_d = 1'b1;
                    state_d     = StRsp;
                end
            end
            StRsp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    txn_d       = txn_q + 8'd1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state_q     <= StIdle;
            start_q     <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            result_q    <= '0;
            txn_q       <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            result_q    <= result_d;
            txn_q       <= txn_d;
        end
    end

    assign cmd_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign alu_start  = start_q;
    assign alu_op     = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = result_q;
    assign txn_count  = txn_q;

endmodule

// File: tb/tb_alu_requester.sv
// Directed, table-driven bench for alu_requester; the bench plays the ALU controller.
module tb_alu_requester;
    import alu_req_pkg::*;

    logic       clk = 1'b0;
    logic       reset_a;
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a, cmd_b;
    logic       alu_start;
    logic [2:0] alu_op;
    logic [7:0] alu_a, alu_b;
    logic       alu_done;
    logic [1:0] alu_state;
    logic [7:0] alu_result;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_error, busy;
    logic [7:0] txn_count;

    int errors = 0;
    int checks = 0;
    int exp_txn = 0;

    alu_requester #(
        .W          (8),
        .OPW        (3),
        .TIMEOUT_CYC(64)
    ) dut (
        .clk       (clk),
        .reset_a   (reset_a),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_start (alu_start),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_done  (alu_done),
        .alu_state (alu_state),
        .alu_result(alu_result),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
        .rsp_error (rsp_error),
        .busy      (busy),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        int         done_lat;
        int         fin_hold;
        int         rsp_hold;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge with the DUT idle; runs one full transaction.
    task automatic run_txn(input vec_t v);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_a     = v.a;
        cmd_b     = v.b;
        alu_state = ALU_ST_IDLE;
        cycle();
        cmd_valid = 1'b0;
        cmd_a     = ~v.a;
        cmd_b     = ~v.b;
        check("start_after_accept", 32'(alu_start), 32'd1);
        check("alu_op", 32'(alu_op), 32'(v.op));
        check("alu_a", 32'(alu_a), 32'(v.a));
        check("alu_b", 32'(alu_b), 32'(v.b));
        check("busy_req", 32'(busy), 32'd1);
        check("cmd_ready_req", 32'(cmd_ready), 32'd0);
        alu_state = ALU_ST_CALC;
        for (int i = 0; i < v.done_lat; i++) begin
            cycle();
            check("req_start_held", 32'(alu_start), 32'd1);
        end
        alu_done   = 1'b1;
        alu_result = v.res;
        cycle();
        alu_done   = 1'b0;
        alu_result = ~v.res;
        check("start_drop_after_done", 32'(alu_start), 32'd0);
        check("rsp_valid_rel", 32'(rsp_valid), 32'd0);
        check("busy_rel", 32'(busy), 32'd1);
        alu_state = ALU_ST_FIN;
        for (int i = 0; i < v.fin_hold; i++) begin
            alu_done = 1'b1;
            cycle();
            check("rel_hold_no_rsp", 32'(rsp_valid), 32'd0);
            check("rel_hold_no_start", 32'(alu_start), 32'd0);
        end
        alu_done  = 1'b0;
        alu_state = ALU_ST_IDLE;
        cycle();
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_result", 32'(rsp_result), 32'(v.res));
        check("rsp_error", 32'(rsp_error), 32'd0);
        for (int i = 0; i < v.rsp_hold; i++) begin
            cmd_valid = 1'b1;
            cmd_a     = 8'h77;
            cycle();
            check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
            check("rsp_hold_result", 32'(rsp_result), 32'(v.res));
            check("rsp_hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check("rsp_hold_alu_a", 32'(alu_a), 32'(v.a));
        end
        // A command offered on the response handshake edge must not be taken.
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        exp_txn   = (exp_txn + 1) % 256;
        check("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
        check("txn_count", 32'(txn_count), 32'(exp_txn));
        check("idle_not_busy", 32'(busy), 32'd0);
        check("no_same_cycle_accept", 32'(alu_start), 32'd0);
    endtask

    initial begin
        vecs[0] = '{3'd0, 8'h12, 8'h34, 8'h46, 4, 0, 0};
        vecs[1] = '{3'd1, 8'hff, 8'h01, 8'h00, 0, 0, 10};
        vecs[2] = '{3'd5, 8'ha5, 8'h5a, 8'hff, 2, 5, 0};
        vecs[3] = '{3'd7, 8'h80, 8'h7f, 8'h01, 1, 1, 3};
        vecs[4] = '{3'd3, 8'h00, 8'h00, 8'h5c, 0, 0, 1};

        reset_a    = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = '0;
        cmd_a      = '0;
        cmd_b      = '0;
        alu_done   = 1'b0;
        alu_state  = ALU_ST_IDLE;
        alu_result = '0;
        rsp_ready  = 1'b0;
        #1;
        check("rst_start", 32'(alu_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_txn", 32'(txn_count), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_a = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            run_txn(vecs[k]);
        end

        // Reset in the middle of REQ drops start immediately and clears everything.
        cmd_valid = 1'b1;
        cmd_op    = 3'd6;
        cmd_a     = 8'h9c;
        cmd_b     = 8'h3e;
        cycle();
        cmd_valid = 1'b0;
        check("pre_reset_start", 32'(alu_start), 32'd1);
        #2;
        reset_a = 1'b1;
        #1;
        check("midrst_start", 32'(alu_start), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_txn", 32'(txn_count), 32'd0);
        check("midrst_alu_op", 32'(alu_op), 32'd0);
        check("midrst_alu_a", 32'(alu_a), 32'd0);
        check("midrst_alu_b", 32'(alu_b), 32'd0);
        check("midrst_rsp_result", 32'(rsp_result), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset_a = 1'b0;
        exp_txn = 0;
        @(negedge clk);

        for (int k = 0; k < 256; k++) begin
            vec_t v;
            v.op       = 3'(k);
            v.a        = 8'(k);
            v.b        = ~8'(k);
            v.res      = 8'(k) ^ 8'h3c;
            v.done_lat = 0;
            v.fin_hold = 0;
            v.rsp_hold = 0;
            run_txn(v);
        end
        check("txn_wrap", 32'(txn_count), 32'd0);

`ifdef ALU_REQ_TIMEOUT_EN
        // No done: start held exactly 64 REQ cycles, then abort with error.
        cmd_valid = 1'b1;
        cmd_a     = 8'h11;
        cycle();
        cmd_valid = 1'b0;
        alu_state = ALU_ST_CALC;
        for (int i = 0; i < 64; i++) begin
            check("to_start_held", 32'(alu_start), 32'd1);
            cycle();
        end
        check("to_start_drop", 32'(alu_start), 32'd0);
        alu_state = ALU_ST_IDLE;
        cycle();
        check("to_rsp_valid", 32'(rsp_valid), 32'd1);
        check("to_rsp_error", 32'(rsp_error), 32'd1);
        check("to_rsp_result", 32'(rsp_result), 32'd0);
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;

        // Done on the 64th REQ cycle wins over the timeout.
        cmd_valid = 1'b1;
        cycle();
        cmd_valid = 1'b0;
        alu_state = ALU_ST_CALC;
        for (int i = 0; i < 63; i++) begin
            cycle();
        end
        alu_done   = 1'b1;
        alu_result = 8'hd7;
        cycle();
        alu_done  = 1'b0;
        alu_state = ALU_ST_IDLE;
        check("to_edge_start_drop", 32'(alu_start), 32'd0);
        cycle();
        check("to_edge_rsp_valid", 32'(rsp_valid), 32'd1);
        check("to_edge_error", 32'(rsp_error), 32'd0);
        check("to_edge_result", 32'(rsp_result), 32'hd7);
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
